// File: rtl/scarv_soc_periph_timer_if.sv
// Memory interface between the core complex (master) and a peripheral responder (slave).
interface scarv_soc_periph_timer_if;
  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport master (
    output req, wen, strb, addr, wdata,
    input  gnt, rdata, error
  );

  modport slave (
    input  req, wen, strb, addr, wdata,
    output gnt, rdata, error
  );
endinterface

// File: rtl/scarv_soc_periph_timer.sv
// Memory-mapped 32-bit down-counting timer with prescaler, auto-reload and level interrupt.
module scarv_soc_periph_timer #(
  parameter logic [31:0] BASE       = 32'h1000_2000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  output logic                       g_clk_req,
  scarv_soc_periph_timer_if.slave    memif,
  output logic                       int_timer
);

  logic                  gnt_q, resp_q, error_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  en_q, en_d, ie_q, ie_d, ar_q, ar_d;
  logic                  pend_q, pend_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [31:0]           count_q, count_d, reload_q, reload_d;
  logic                  int_q;

  logic       fire, wr, rd, bad, tick, expire;
  logic       sel_ctrl, sel_status, sel_pre, sel_count, sel_reload;
  logic [5:0] off;

  // Window decode is done by the interconnect; only the word offset matters here.
  logic unused_addr;
  assign unused_addr = ^{memif.addr[31:8] ^ BASE[31:8], memif.addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  assign off        = memif.addr[7:2];
  assign fire       = memif.req & gnt_q;
  assign wr         = fire & memif.wen;
  assign rd         = fire & ~memif.wen;
  assign sel_ctrl   = (off == 6'd0);
  assign sel_status = (off == 6'd1);
  assign sel_pre    = (off == 6'd2);
  assign sel_count  = (off == 6'd3);
  assign sel_reload = (off == 6'd4);
  assign bad        = (off > 6'd4);

  assign tick   = en_q & (pcnt_q == prescale_q);
  assign expire = tick & (count_q == 32'd0);

  // Next-state for all timer registers; CPU writes take priority over tick effects,
  // except that a PEND set beats a concurrent write-1-clear.
  always_comb begin
    en_d       = en_q;
    ie_d       = ie_q;
    ar_d       = ar_q;
    pend_d     = pend_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    reload_d   = reload_q;
    pcnt_d     = pcnt_q;

    if (!en_q || tick) pcnt_d = '0;
    else               pcnt_d = pcnt_q + PRESCALE_W'(1);

    if (tick) begin
      if (count_q != 32'd0) count_d = count_q - 32'd1;
      else if (ar_q)        count_d = reload_q;
    end
    if (expire && !ar_q) en_d = 1'b0;

    if (wr && sel_ctrl && memif.strb[0]) begin
      en_d = memif.wdata[0];
      ie_d = memif.wdata[1];
      ar_d = memif.wdata[2];
    end
    if (wr && sel_status && memif.strb[0] && memif.wdata[0]) pend_d = 1'b0;
    if (expire) pend_d = 1'b1;
    if (wr && sel_pre) begin
      prescale_d = PRESCALE_W'(merge(32'(prescale_q), memif.wdata, memif.strb));
      pcnt_d     = '0;
    end
    if (wr && sel_count) begin
      count_d = merge(count_q, memif.wdata, memif.strb);
      pcnt_d  = '0;
    end
    if (wr && sel_reload) reload_d = merge(reload_q, memif.wdata, memif.strb);
  end

  // Read mux; returns the pre-update register value of the request cycle.
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (1'b1)
        sel_ctrl:   rdata_d = {29'd0, ar_q, ie_q, en_q};
        sel_status: rdata_d = {31'd0, pend_q};
        sel_pre:    rdata_d = 32'(prescale_q);
        sel_count:  rdata_d = count_q;
        sel_reload: rdata_d = reload_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // Timer state registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      ar_q       <= 1'b0;
      pend_q     <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      reload_q   <= '0;
      int_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      ar_q       <= ar_d;
      pend_q     <= pend_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      int_q      <= pend_q & ie_q;
    end
  end

  // Bus grant and one-cycle response registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      gnt_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      gnt_q   <= 1'b1;
      resp_q  <= fire;
      rdata_q <= rdata_d;
      error_q <= fire & bad;
    end
  end

  assign memif.gnt   = gnt_q;
  assign memif.rdata = rdata_q;
  assign memif.error = error_q;
  assign int_timer   = int_q;
  assign g_clk_req   = en_q | memif.req | resp_q;

endmodule
